// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 op codes,
// FSM state encoding and operand signedness helpers.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and
// for restoring the sign of the final result.
module muldiv_unit_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] value_o
);

    assign value_o = neg_i ? ('0 - value_i) : value_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit with a busy/valid handshake
// and pipeline-flush support. One 2W accumulator is shared by mul and div.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [1:0]            state_o
);

    // Handshake: a start is taken only in IDLE with flush low; busy covers that
    // cycle through DONE. valid pulses for the single DONE cycle and result_o
    // carries the final value then; otherwise it shows the last committed result.

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] COUNT_INIT = CW'(DATA_WIDTH - 1);
    localparam logic [W-1:0]  MOST_NEG   = {1'b1, {(W-1){1'b0}}};

    state_e          state_q;
    logic [2:0]      op_q;
    logic [2*W-1:0]  acc_q;
    logic [W-1:0]    operand_q;
    logic [CW-1:0]   count_q;
    logic            neg_q;
    logic [W-1:0]    result_q;

    logic            a_neg, b_neg, res_sign;
    logic [W-1:0]    a_mag, b_mag;
    logic            is_div_i, div_by_zero, div_ovf, accept;

    assign accept      = (state_q == ST_IDLE) && start_i && !flush_i;
    assign a_neg       = op_a_signed(op_i) && operand_a_i[W-1];
    assign b_neg       = op_b_signed(op_i) && operand_b_i[W-1];
    assign res_sign    = (op_i == OP_REM) ? a_neg : (a_neg ^ b_neg);
    assign is_div_i    = op_i[2];
    assign div_by_zero = is_div_i && (operand_b_i == '0);
    assign div_ovf     = is_div_i && !op_i[0] && (operand_a_i == MOST_NEG)
                         && (operand_b_i == {W{1'b1}});

    muldiv_unit_negate #(.WIDTH(W)) u_neg_a (
        .value_i (operand_a_i),
        .neg_i   (a_neg),
        .value_o (a_mag)
    );

    muldiv_unit_negate #(.WIDTH(W)) u_neg_b (
        .value_i (operand_b_i),
        .neg_i   (b_neg),
        .value_o (b_mag)
    );

    // Multiply step: multiplier sits in the low half and shifts out LSB-first.
    logic [W-1:0]   mul_addend;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_step;

    assign mul_addend = acc_q[0] ? operand_q : '0;
    assign mul_sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, mul_addend};
    assign mul_step   = {mul_sum, acc_q[W-1:1]};

    // Divide step: {rem,quo} shifts left; the shifted remainder needs W+1 bits.
    logic [W:0]     div_rem_sh;
    logic           div_ge;
    logic [W-1:0]   div_rem_new;
    logic [2*W-1:0] div_step;
    logic [2*W-1:0] acc_step;

    assign div_rem_sh  = acc_q[2*W-1:W-1];
    assign div_ge      = div_rem_sh >= {1'b0, operand_q};
    assign div_rem_new = div_ge ? (div_rem_sh[W-1:0] - operand_q) : div_rem_sh[W-1:0];
    assign div_step    = {div_rem_new, acc_q[W-2:0], div_ge};
    assign acc_step    = op_q[2] ? div_step : mul_step;

    // MULH* needs the full 2W product negated; div results are selected first.
    logic           pick_high;
    logic [2*W-1:0] fix_in, fix_out;
    logic [W-1:0]   final_res;

    assign pick_high = op_q[2] ? op_q[1] : (op_q[1:0] != 2'b00);
    assign fix_in    = op_q[2] ? {{W{1'b0}}, (pick_high ? acc_q[2*W-1:W] : acc_q[W-1:0])}
                               : acc_q;

    muldiv_unit_negate #(.WIDTH(2*W)) u_neg_res (
        .value_i (fix_in),
        .neg_i   (neg_q),
        .value_o (fix_out)
    );

    assign final_res = (!op_q[2] && pick_high) ? fix_out[2*W-1:W] : fix_out[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            operand_q <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q <= op_i;
                        if (div_by_zero) begin
                            acc_q   <= {operand_a_i, {W{1'b1}}};
                            neg_q   <= 1'b0;
                            state_q <= ST_DONE;
                        end else if (div_ovf) begin
                            acc_q   <= {{W{1'b0}}, operand_a_i};
                            neg_q   <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            acc_q     <= {{W{1'b0}}, (is_div_i ? a_mag : b_mag)};
                            operand_q <= is_div_i ? b_mag : a_mag;
                            neg_q     <= res_sign;
                            count_q   <= COUNT_INIT;
                            state_q   <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q   <= acc_step;
                        count_q <= count_q - 1'b1;
                        if (count_q == '0) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!flush_i) begin
                        result_q <= final_res;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o   = (state_q != ST_IDLE) || accept;
    assign valid_o  = (state_q == ST_DONE) && !flush_i;
    assign result_o = valid_o ? final_res : result_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (DATA_WIDTH=32): latency, results, special
// cases, ignored start, back-to-back, flush and asynchronous reset.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;
    localparam int BUDGET = 100;

    logic        clk, rst_n, start, flush, busy, valid;
    logic [2:0]  op;
    logic [31:0] a, b, result;
    logic [1:0]  state;

    logic [31:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .op_i        (op),
        .operand_a_i (a),
        .operand_b_i (b),
        .flush_i     (flush),
        .busy_o      (busy),
        .valid_o     (valid),
        .result_o    (result),
        .state_o     (state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drivers: caller is at a negedge; start is held across one rising edge
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int cyc;
        logic found;
        logic [31:0] exp;
        exp   = exp_q.pop_front();
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < BUDGET) begin
            cyc++;
            @(negedge clk);
            if (valid) found = 1'b1;
        end
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_res"}, result, exp);
        @(negedge clk);
        check({tag, "_pulse"}, valid, 1'b0);
        check({tag, "_hold"}, result, exp);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
        @(negedge clk);
        exp_q.push_back(exp);
        issue(o, x, y);
        wait_result(tag, exp_lat);
    endtask

    initial begin
        int nvalid;
        int vcyc;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        #3;
        check("rst_busy",   busy,   1'b0);
        check("rst_valid",  valid,  1'b0);
        check("rst_result", result, 32'h0);
        check("rst_state",  state,  2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed vectors
        run_op("mul_7_m3",     OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_op("mulh_min",     OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
        run_op("mulhu_max",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("mulhsu_m1",    OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        run_op("div_m7_2",     OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        run_op("rem_m7_2",     OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        run_op("div_20_m3",    OP_DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33);
        run_op("rem_20_m3",    OP_REM,    32'd20,       32'hFFFFFFFD, 32'd2,        33);
        run_op("div_5_0",      OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("remu_5_0",     OP_REMU,   32'd5,        32'd0,        32'd5,        1);
        run_op("div_ovf",      OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",      OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
        run_op("divu_100_7",   OP_DIVU,   32'd100,      32'd7,        32'd14,       33);
        run_op("remu_100_7",   OP_REMU,   32'd100,      32'd7,        32'd2,        33);

        // start while busy is ignored; next start right after valid is taken
        @(negedge clk);
        issue(OP_MUL, 32'd3, 32'd5);
        nvalid = 0;
        vcyc   = 0;
        for (int cyc = 1; cyc <= 33; cyc++) begin
            @(negedge clk);
            if (cyc == 10) begin
                start = 1'b1;
                op    = OP_DIVU;
                a     = 32'd100;
                b     = 32'd7;
                #1 check("ign_busy", busy, 1'b1);
            end
            if (cyc == 11) start = 1'b0;
            if (valid) begin
                nvalid++;
                vcyc = cyc;
            end
        end
        check("ign_nvalid", nvalid, 1);
        check("ign_vcyc",   vcyc,   33);
        check("ign_res",    result, 32'd15);
        @(negedge clk);
        check("b2b_idle_valid", valid, 1'b0);
        exp_q.push_back(32'd14);
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        #1 check("b2b_busy", busy, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_result("b2b", 33);

        // flush mid-CALC
        @(negedge clk);
        issue(OP_DIV, 32'd1000, 32'd3);
        nvalid = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 15) flush = 1'b1;
            if (cyc == 16) begin
                flush = 1'b0;
                #1 check("flush_busy16", busy, 1'b0);
            end
            if (valid) nvalid++;
        end
        check("flush_nvalid", nvalid, 0);
        check("flush_res",    result, 32'd14);

        // start together with flush is not accepted
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = OP_MUL;
        a     = 32'd2;
        b     = 32'd2;
        #1 check("sf_busy", busy, 1'b0);
        @(posedge clk);
        #1 begin
            start = 1'b0;
            flush = 1'b0;
        end
        @(negedge clk);
        check("sf_state", state, 2'd0);
        check("sf_busy2", busy,  1'b0);

        // flush in DONE suppresses the valid of a special-case divide
        @(negedge clk);
        issue(OP_DIV, 32'd5, 32'd0);
        @(negedge clk);
        flush = 1'b1;
        #1 begin
            check("fdone_valid", valid,  1'b0);
            check("fdone_res",   result, 32'd14);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("fdone_res2", result, 32'd14);
        check("fdone_busy", busy,   1'b0);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        issue(OP_MUL, 32'd9, 32'd9);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 begin
            check("arst_busy",   busy,   1'b0);
            check("arst_valid",  valid,  1'b0);
            check("arst_result", result, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_mul", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
